// File: rtl/pb_axil_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pb_axil_pkg
// Description : Shared constants, FSM state types and the register-select
//               helper for the picoBlaze / AXI4-Lite register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_axil_pkg;

  localparam int NUM_REGS = 4;

  // Register indices, taken from byte-address bits [3:2]
  localparam logic [1:0] REG0 = 2'd0;
  localparam logic [1:0] REG1 = 2'd1;
  localparam logic [1:0] REG2 = 2'd2;
  localparam logic [1:0] REG3 = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Pick one 32-bit word out of the bank by register index
  function automatic logic [31:0] sel_word(input logic [NUM_REGS-1:0][31:0] bank,
                                           input logic [1:0] idx);
    logic [31:0] word;
    word = '0;
    case (idx)
      REG0: word = bank[0];
      REG1: word = bank[1];
      REG2: word = bank[2];
      REG3: word = bank[3];
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_axil_regbank_if.sv
`default_nettype none
// ============================================================================
// Interface   : pb_axil_regbank_if
// Description : AXI4-Lite slave bus (no PROT signals) for the register bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface pb_axil_regbank_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface
`default_nettype wire

// File: rtl/pb_regbank_bytewr.sv
`default_nettype none
// ============================================================================
// Module      : pb_regbank_bytewr
// Description : One 32-bit register with per-byte merge of an AXI strobed
//               write and a picoBlaze single-byte write; AXI wins a byte
//               when both target it in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_regbank_bytewr
  import pb_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        axi_we,
  input  logic [31:0] axi_data,
  input  logic [3:0]  axi_strb,
  input  logic        pb_we,
  input  logic [1:0]  pb_byte,
  input  logic [7:0]  pb_data,
  output logic [31:0] q
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    logic [7:0] byte_q;

    // Each byte lane updates on its own: AXI strobe first, then picoBlaze
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        byte_q <= '0;
      end else if (axi_we && axi_strb[b]) begin
        byte_q <= axi_data[8*b +: 8];
      end else if (pb_we && (pb_byte == 2'(b))) begin
        byte_q <= pb_data;
      end
    end

    assign q[8*b +: 8] = byte_q;
  end

endmodule
`default_nettype wire

// File: rtl/pb_axil_regbank.sv
`default_nettype none
// ============================================================================
// Module      : pb_axil_regbank
// Description : Four 32-bit registers shared between an AXI4-Lite slave and
//               a picoBlaze I/O port. Independent write and read FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_axil_regbank
  import pb_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
)(
  input  logic                    ACLK,
  input  logic                    ARESETN,
  pb_axil_regbank_if.slave        s_axi,
  input  logic [7:0]              pb_port_id,
  input  logic                    pb_write_strobe,
  input  logic [7:0]              pb_out_port,
  output logic [7:0]              pb_in_port
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic                          aw_held, w_held;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic                          awready, wready, bvalid;
  logic                          arready, rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  logic [NUM_REGS-1:0][31:0]     bank;

  logic                          aw_fire, w_fire, have_aw, have_w, commit;
  logic [1:0]                    commit_idx;
  logic [31:0]                   commit_data;
  logic [3:0]                    commit_strb;
  logic [31:0]                   pb_word;

  // A beat is either already held or arriving this cycle; commit once both exist
  assign aw_fire     = s_axi.S_AXI_AWVALID & awready;
  assign w_fire      = s_axi.S_AXI_WVALID & wready;
  assign have_aw     = aw_held | aw_fire;
  assign have_w      = w_held | w_fire;
  assign commit      = (wr_state == W_IDLE) & have_aw & have_w;
  assign commit_idx  = aw_held ? aw_idx  : s_axi.S_AXI_AWADDR[3:2];
  assign commit_data = w_held  ? wdata_q : s_axi.S_AXI_WDATA;
  assign commit_strb = w_held  ? wstrb_q : s_axi.S_AXI_WSTRB;

  // Write FSM: collect AW and W in any order, commit, then hold BVALID
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (commit) begin
            wr_state <= W_RESP;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
          end else begin
            if (aw_fire) begin
              aw_held <= 1'b1;
              aw_idx  <= s_axi.S_AXI_AWADDR[3:2];
            end
            if (w_fire) begin
              w_held  <= 1'b1;
              wdata_q <= s_axi.S_AXI_WDATA;
              wstrb_q <= s_axi.S_AXI_WSTRB;
            end
            awready <= ~have_aw;
            wready  <= ~have_w;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            wr_state <= W_IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: sample the bank on the AR handshake, hold data until RREADY
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_axi.S_AXI_ARVALID && arready) begin
            rdata    <= sel_word(bank, s_axi.S_AXI_ARADDR[3:2]);
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            rd_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    pb_regbank_bytewr u_bytewr (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .axi_we   (commit && (commit_idx == 2'(i))),
      .axi_data (commit_data),
      .axi_strb (commit_strb),
      .pb_we    (pb_write_strobe && (pb_port_id[3:2] == 2'(i))),
      .pb_byte  (pb_port_id[1:0]),
      .pb_data  (pb_out_port),
      .q        (bank[i])
    );
  end

  assign pb_word = sel_word(bank, pb_port_id[3:2]);

  // picoBlaze INPUT path: one-cycle registered byte select
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pb_in_port <= '0;
    end else begin
      pb_in_port <= pb_word[{pb_port_id[1:0], 3'b000} +: 8];
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;

  // Byte-offset bits and the upper port-id nibble do not select anything
  logic unused_sel_bits;
  assign unused_sel_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], pb_port_id[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_pb_axil_regbank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pb_axil_regbank
// Description : Directed self-checking bench for pb_axil_regbank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_axil_regbank;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [7:0] pb_port_id;
  logic       pb_write_strobe;
  logic [7:0] pb_out_port;
  logic [7:0] pb_in_port;

  int n_assert = 0;
  int n_fail   = 0;

  pb_axil_regbank_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  pb_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .s_axi           (bus),
    .pb_port_id      (pb_port_id),
    .pb_write_strobe (pb_write_strobe),
    .pb_out_port     (pb_out_port),
    .pb_in_port      (pb_in_port)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full AXI write; optionally fires a picoBlaze write on the commit cycle
  task automatic axi_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic pb_en,
                           input logic [7:0] pb_id, input logic [7:0] pb_val);
    logic aw_go, w_go, got_b;
    logic [1:0] resp;
    got_b = 1'b0;
    resp  = 2'bxx;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    pb_write_strobe   = pb_en;
    pb_port_id        = pb_id;
    pb_out_port       = pb_val;
    for (int c = 0; c < 20 && (bus.S_AXI_AWVALID || bus.S_AXI_WVALID); c++) begin
      aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge ACLK);
      pb_write_strobe = 1'b0;
      if (aw_go) bus.S_AXI_AWVALID = 1'b0;
      if (w_go)  bus.S_AXI_WVALID  = 1'b0;
    end
    for (int c = 0; c < 20 && !got_b; c++) begin
      if (bus.S_AXI_BVALID) begin
        got_b = 1'b1;
        resp  = bus.S_AXI_BRESP;
      end
      @(negedge ACLK);
    end
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check(tag, {27'b0, aw_go, w_go, got_b, resp}, {27'b0, 1'b1, 1'b1, 1'b1, 2'b00});
  endtask

  // Full AXI read, checking data and {ar accepted, rvalid seen, rresp}
  task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic ar_go, got_r;
    logic [31:0] d;
    logic [1:0]  r;
    ar_go = 1'b0;
    got_r = 1'b0;
    d     = 'x;
    r     = 2'bxx;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    for (int c = 0; c < 20 && bus.S_AXI_ARVALID; c++) begin
      ar_go = bus.S_AXI_ARREADY;
      @(negedge ACLK);
      if (ar_go) bus.S_AXI_ARVALID = 1'b0;
    end
    for (int c = 0; c < 20 && !got_r; c++) begin
      if (bus.S_AXI_RVALID) begin
        got_r = 1'b1;
        d     = bus.S_AXI_RDATA;
        r     = bus.S_AXI_RRESP;
      end
      @(negedge ACLK);
    end
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    check({tag, ".data"}, d, exp);
    check({tag, ".hs"}, {28'b0, ar_go, got_r, r}, {28'b0, 1'b1, 1'b1, 2'b00});
  endtask

  initial begin
    int bv, blk;
    ARESETN = 1'b0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    pb_port_id = '0; pb_write_strobe = 1'b0; pb_out_port = '0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst.flags", {27'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                        bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h0);
    check("rst.rdata", bus.S_AXI_RDATA, 32'h0);
    check("rst.pbin", {24'b0, pb_in_port}, 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("post_rst.ready", {29'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h7);

    // Basic writes and read-back
    axi_write("wr0", 4'h0, 32'h1, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_write("wr1", 4'h4, 32'h2, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_write("wr2", 4'h8, 32'h3, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_write("wr3", 4'hC, 32'h4, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_read("rd0", 4'h0, 32'h1);
    axi_read("rd1", 4'h4, 32'h2);
    axi_read("rd2", 4'h8, 32'h3);
    axi_read("rd3", 4'hC, 32'h4);

    // picoBlaze input path: REG1 byte0
    pb_port_id = 8'h04;
    @(negedge ACLK);
    check("pbin.reg1b0", {24'b0, pb_in_port}, 32'h02);

    // Byte-strobe merge
    axi_write("strb.full", 4'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_write("strb.0101", 4'h4, 32'h1234_5678, 4'b0101, 1'b0, 8'h00, 8'h00);
    axi_read("strb.rd", 4'h4, 32'hFF34_FF78);
    axi_write("strb.none", 4'h4, 32'h0, 4'b0000, 1'b0, 8'h00, 8'h00);
    axi_read("strb.none.rd", 4'h4, 32'hFF34_FF78);

    // W three cycles ahead of AW, BREADY held low for five cycles
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_WDATA  = 32'hCAFE_0001;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 1'b0;
    check("wfirst.ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h2);
    @(negedge ACLK);
    @(negedge ACLK);
    bus.S_AXI_AWADDR  = 4'hC;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_AWADDR  = 4'h0;
    bus.S_AXI_WDATA   = 32'hDEAD_BEEF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bv  = 0;
    blk = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.S_AXI_BVALID) bv++;
      if (bus.S_AXI_AWREADY || bus.S_AXI_WREADY) blk++;
      @(negedge ACLK);
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("bhold.count", 32'(bv), 32'd5);
    check("bhold.blocked", 32'(blk), 32'd0);
    check("bhold.still", {31'b0, bus.S_AXI_BVALID}, 32'h1);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 1'b0;
    check("bhold.done", {30'b0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, 32'h1);
    @(negedge ACLK);
    check("bhold.single", {31'b0, bus.S_AXI_BVALID}, 32'h0);
    axi_read("bhold.rd3", 4'hC, 32'hCAFE_0001);
    axi_read("bhold.rd0", 4'h0, 32'h1);

    // AXI versus picoBlaze on REG2 byte1
    axi_write("col.clr", 4'h8, 32'h0, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_write("col.axi", 4'h8, 32'h0000_1100, 4'b0010, 1'b1, 8'h09, 8'hAA);
    axi_read("col.axi.rd", 4'h8, 32'h0000_1100);
    axi_write("col.clr2", 4'h8, 32'h0, 4'hF, 1'b0, 8'h00, 8'h00);
    axi_write("col.pb", 4'h8, 32'h0000_1100, 4'b0001, 1'b1, 8'h09, 8'hAA);
    axi_read("col.pb.rd", 4'h8, 32'h0000_AA00);
    pb_port_id = 8'h09;
    @(negedge ACLK);
    check("pbin.reg2b1", {24'b0, pb_in_port}, 32'hAA);

    // picoBlaze write alone; upper port-id nibble ignored
    pb_port_id      = 8'hFF;
    pb_out_port     = 8'h5A;
    pb_write_strobe = 1'b1;
    @(negedge ACLK);
    pb_write_strobe = 1'b0;
    axi_read("pbwr.rd3", 4'hC, 32'h5AFE_0001);

    // Read and write commit to REG0 in the same cycle
    bus.S_AXI_AWADDR  = 4'h0;
    bus.S_AXI_WDATA   = 32'h77;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_ARADDR  = 4'h0;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    check("raw.valids", {30'b0, bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 32'h3);
    check("raw.rdata", bus.S_AXI_RDATA, 32'h1);
    @(negedge ACLK);
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    check("raw.done", {30'b0, bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 32'h0);
    axi_read("raw.after", 4'h0, 32'h77);

    // Reset between AW and W: the held AW must be discarded
    bus.S_AXI_AWADDR  = 4'h4;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    check("mid.awheld", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    check("mid.inrst", {27'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                        bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("mid.ready", {29'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h7);
    bus.S_AXI_WDATA  = 32'h5555_5555;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 1'b0;
    bv = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.S_AXI_BVALID) bv++;
      @(negedge ACLK);
    end
    bus.S_AXI_BREADY = 1'b0;
    check("mid.nobvalid", 32'(bv), 32'd0);
    axi_read("mid.rd0", 4'h0, 32'h0);
    axi_read("mid.rd1", 4'h4, 32'h0);
    axi_read("mid.rd2", 4'h8, 32'h0);
    axi_read("mid.rd3", 4'hC, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pb_axil_regbank.md
PB_AXIL_REGBANK -- requirements
Module: pb_axil_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width, fixed at 32.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width covering 4 x 32-bit registers.
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETN  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port S_AXI_AWADDR  in  4  write address; bits [3:2] select the register.
REQ-006 SHALL have port S_AXI_AWVALID  in  1  and S_AXI_AWREADY  out  1: the write-address handshake.
REQ-007 SHALL have port S_AXI_WDATA  in  32  write data.
REQ-008 SHALL have port S_AXI_WSTRB  in  4  byte-lane enables.
REQ-009 SHALL have port S_AXI_WVALID  in  1  and S_AXI_WREADY  out  1: the write-data handshake.
REQ-010 SHALL have port S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY).
REQ-011 SHALL have port S_AXI_BVALID  out  1  and S_AXI_BREADY  in  1: the write-response handshake.
REQ-012 SHALL have port S_AXI_ARADDR  in  4  read address; bits [3:2] select the register.
REQ-013 SHALL have port S_AXI_ARVALID  in  1  and S_AXI_ARREADY  out  1: the read-address handshake.
REQ-014 SHALL have port S_AXI_RDATA  out  32  read data.
REQ-015 SHALL have port S_AXI_RRESP  out  2  read response, always 2'b00 (OKAY).
REQ-016 SHALL have port S_AXI_RVALID  out  1  and S_AXI_RREADY  in  1: the read-data handshake.
REQ-017 SHALL have port pb_port_id  in  8  picoBlaze port address; [3:2] selects the register, [1:0] the byte; [7:4] is ignored.
REQ-018 SHALL have port pb_write_strobe  in  1  picoBlaze OUTPUT strobe.
REQ-019 SHALL have port pb_out_port  in  8  picoBlaze output byte.
REQ-020 SHALL have port pb_in_port  out  8  registered byte returned to the picoBlaze INPUT instruction.
REQ-021 SHALL have no AWPROT/ARPROT ports; protection attributes are unused.

Function
REQ-022 SHALL hold four 32-bit registers REG0..REG3 at byte offsets 0x0, 0x4, 0x8 and 0xC; address bits [1:0] are ignored.
REQ-023 SHALL use a write FSM with states W_IDLE and W_RESP:
- In W_IDLE, AWREADY=1 until the AW beat is captured, and WREADY=1 until the W beat is captured; AW and W may arrive in either order or in the same cycle.
- When both beats are held, it SHALL commit the write on that clock edge and enter W_RESP with BVALID=1 on the next cycle.
REQ-024 SHALL hold BVALID=1 in W_RESP until BREADY=1, then return to W_IDLE; AWREADY=WREADY=0 throughout W_RESP.
REQ-025 SHALL update, on an AXI write commit, only the byte lanes whose WSTRB bit is 1; WSTRB=0 SHALL complete the handshake with no register change.
REQ-026 SHALL use a read FSM with states R_IDLE and R_DATA:
- In R_IDLE, ARREADY=1.
- On the AR handshake it SHALL register RDATA from the addressed register and enter R_DATA with RVALID=1 on the next cycle.
REQ-027 SHALL hold RVALID and RDATA stable in R_DATA until RREADY=1, then return to R_IDLE; ARREADY=0 throughout R_DATA.
REQ-028 SHALL return the pre-write register value when an AR handshake and a write commit to the same register occur in the same cycle.
REQ-029 SHALL, on pb_write_strobe=1, write pb_out_port into REG[port_id[3:2]] byte port_id[1:0] at the next edge.
REQ-030 SHALL, on a same-cycle collision between an AXI commit and a picoBlaze write to the same byte with WSTRB set, give priority to the AXI value; all other bytes SHALL be updated independently.
REQ-031 SHALL register pb_in_port every cycle from REG[port_id[3:2]] byte port_id[1:0] (1-cycle latency, valid for picoBlaze INPUT sampling).

Reset
REQ-032 SHALL, while ARESETN=0 at a rising edge, clear all registers and set AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0, pb_in_port=0, with both FSMs returned to IDLE and any captured AW/W beats discarded.
REQ-033 SHALL assert AWREADY, WREADY and ARREADY on the first cycle after ARESETN returns to 1.

Structure
REQ-034 SHALL place the register index constants (REG0..REG3), the OKAY response code and the FSM state enums in package pb_axil_pkg.
REQ-035 SHALL implement the byte-write merge and priority logic as sub-module pb_regbank_bytewr, instantiated once per register.

Verification
REQ-036 SHALL cover: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read the same addresses -> reads return 0x1..0x4 with RRESP=0 and BRESP=0.
REQ-037 SHALL cover: REG1=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> read of 0x4 returns 0xFF34FF78.
REQ-038 SHALL cover: W presented 3 cycles before AW and BREADY held low for 5 cycles -> exactly one commit, BVALID stays high for 5 cycles, and no new AW/W is accepted in that window.
REQ-039 SHALL cover: picoBlaze writes 0xAA to port 0x09 while AXI writes 0x00001100 to 0x8 with WSTRB=4'b0010 -> REG2=0x00001100; with WSTRB=4'b0001 instead -> REG2=0x0000AA00.
REQ-040 SHALL cover: ARESETN pulled low after the AW beat is accepted but before the W beat -> BVALID never asserts and all registers read 0 after reset.
